quad_encoder: RTL

- Quadrature waveform generator: the transmit-side counterpart of the team's quadrature decoder (`quad`).
- Accepts step commands (direction plus step count) over a valid/ready handshake and emits quadA/quadB with one Gray-code edge per step, at a programmable edge spacing.
- Tracks its own position counter; the decoder sees the same count when looped back.
- Used for motor-interface bring-up, stepper-style drive, and decoder loopback test.

---
 rtl/quad_pkg.sv | 14 +
 rtl/quad_edge_timer.sv | 29 ++
 rtl/quad_encoder.sv | 70 +++++++
 3 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: shared state enum, AB phase encodings and the Gray-code phase stepper
package quad_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    return phase == PH_00 ? (dir ? PH_10 : PH_01) :
           phase == PH_10 ? (dir ? PH_11 : PH_00) :
           phase == PH_11 ? (dir ? PH_01 : PH_10) :
                            (dir ? PH_00 : PH_11);
  endfunction
endpackage

// File: rtl/quad_edge_timer.sv
// quad_edge_timer: reloadable edge-spacing down-counter; tick marks the edge cycle (timer==1)
module quad_edge_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] period_q, timer_q, period_d;
  assign period_d = period == '0 ? DIV_W'(1) : period;
  assign tick = timer_q == DIV_W'(1);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q <= '0;
      timer_q  <= '0;
    end else if (clear) begin
      timer_q <= '0;
    end else if (load) begin
      period_q <= period_d;
      timer_q  <= period_d;
    end else if (en) begin
      timer_q <= tick ? period_q : timer_q - DIV_W'(1);
    end
  end
endmodule

// File: rtl/quad_encoder.sv
// quad_encoder: step-command driven quadrature A/B generator with position and step tracking
module quad_encoder
  import quad_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DIV_W-1:0]  edge_period,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              quadA,
  output logic              quadB,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left,
  output logic [CNT_W-1:0]  position
);
  state_e            state_q;
  logic              dir_q;
  logic [1:0]        ab_q;
  logic [CNT_W-1:0]  pos_q;
  logic [STEP_W-1:0] steps_q;
  logic              run, tick, go, fire, last, stop;
  assign run  = state_q == RUN;
  assign cmd_ready = resetn & ~run;
  assign busy = run;
  assign go   = cmd_valid & cmd_ready & (|cmd_steps);
  assign stop = run & abort;
  assign fire = run & tick & ~abort;
  assign last = fire & (steps_q == STEP_W'(1));
  assign quadA = ab_q[1];
  assign quadB = ab_q[0];
  assign steps_left = steps_q;
  assign position = pos_q;
  quad_edge_timer #(.DIV_W(DIV_W)) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .load  (go),
    .clear (stop | last),
    .en    (run),
    .period(edge_period),
    .tick  (tick)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      ab_q    <= PH_00;
      pos_q   <= '0;
      steps_q <= '0;
    end else if (stop) begin
      state_q <= IDLE;
      steps_q <= '0;
    end else if (go) begin
      state_q <= RUN;
      dir_q   <= cmd_dir;
      steps_q <= cmd_steps;
    end else if (fire) begin
      ab_q    <= next_phase(ab_q, dir_q);
      pos_q   <= dir_q ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
      steps_q <= steps_q - STEP_W'(1);
      state_q <= last ? IDLE : RUN;
    end
  end
endmodule
